// File: rtl/uart_transceiver.sv
// uart_transceiver
//   Single-clock UART with an independent transmitter and receiver.
//   Framing: one start bit (0), DATA_BITS data bits LSB first, one stop bit (1).
//   Every bit lasts CLKS_PER_BIT clock cycles; there is no baud generator or FIFO.
//
// Ports
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   tx_data  byte to transmit, captured when a frame starts
//   tx_send  level-sensitive transmit request; held high gives back-to-back frames
//   tx_sent  one-cycle pulse in the last cycle of each stop bit
//   tx       registered serial output, idle high
//   rx       asynchronous serial input
//   rx_data  last correctly framed byte
//   rx_recv  one-cycle strobe, rx_data valid in the same cycle
module uart_transceiver #(
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_send,
    output logic                 tx_sent,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_recv
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;

    tx_state_e              tx_state_q, tx_state_d;
    logic [CntW-1:0]        tx_cnt_q, tx_cnt_d;
    logic [IdxW-1:0]        tx_idx_q, tx_idx_d;
    logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
    logic                   tx_q, tx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TxIdle;
            tx_cnt_q   <= '0;
            tx_idx_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_idx_q   <= tx_idx_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

    // tx_d is the line level for the cycle after this edge, so every
    // transition loads the level of the bit being entered.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_idx_d   = tx_idx_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        tx_sent    = 1'b0;

        unique case (tx_state_q)
            TxIdle: begin
                tx_d = 1'b1;
                if (tx_send) begin
                    tx_state_d = TxStart;
                    tx_cnt_d   = '0;
                    tx_shift_d = tx_data;
                    tx_d       = 1'b0;
                end
            end
            TxStart: begin
                if (tx_cnt_q == CntLast) begin
                    tx_state_d = TxData;
                    tx_cnt_d   = '0;
                    tx_idx_d   = '0;
                    tx_d       = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxData: begin
                if (tx_cnt_q == CntLast) begin
                    tx_cnt_d = '0;
                    if (tx_idx_q == IdxLast) begin
                        tx_state_d = TxStop;
                        tx_d       = 1'b1;
                    end else begin
                        tx_idx_d   = tx_idx_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TxStop: begin
                tx_d = 1'b1;
                if (tx_cnt_q == CntLast) begin
                    tx_sent  = 1'b1;
                    tx_cnt_d = '0;
                    // No idle gap: a pending request starts the next frame here.
                    if (tx_send) begin
                        tx_state_d = TxStart;
                        tx_shift_d = tx_data;
                        tx_d       = 1'b0;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_state_d = TxIdle;
                tx_d       = 1'b1;
            end
        endcase
    end

    assign tx = tx_q;

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {RxIdle, RxStart, RxData, RxStop, RxWait} rx_state_e;

    rx_state_e              rx_state_q, rx_state_d;
    logic [CntW-1:0]        rx_cnt_q, rx_cnt_d;
    logic [IdxW-1:0]        rx_idx_q, rx_idx_d;
    logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_recv_q, rx_recv_d;
    logic                   rx_meta_q, rx_meta_d;
    logic                   rx_sync_q, rx_sync_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q <= RxIdle;
            rx_cnt_q   <= '0;
            rx_idx_q   <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            rx_recv_q  <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_idx_q   <= rx_idx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_recv_q  <= rx_recv_d;
            rx_meta_q  <= rx_meta_d;
            rx_sync_q  <= rx_sync_d;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_idx_d   = rx_idx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_recv_d  = 1'b0;
        rx_meta_d  = rx;
        rx_sync_d  = rx_meta_q;

        unique case (rx_state_q)
            RxIdle: begin
                if (!rx_sync_q) begin
                    rx_state_d = RxStart;
                    rx_cnt_d   = '0;
                end
            end
            RxStart: begin
                // Mid-bit recheck rejects glitches shorter than half a bit.
                if (rx_cnt_q == CntMid) begin
                    rx_cnt_d = '0;
                    rx_idx_d = '0;
                    rx_state_d = rx_sync_q ? RxIdle : RxData;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxData: begin
                // Counter was restarted at mid start bit, so wrap points are mid-bit.
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_idx_q == IdxLast) begin
                        rx_state_d = RxStop;
                    end else begin
                        rx_idx_d = rx_idx_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxStop: begin
                if (rx_cnt_q == CntLast) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        // Leave at mid stop bit to gain margin on back-to-back frames.
                        rx_data_d  = rx_shift_q;
                        rx_recv_d  = 1'b1;
                        rx_state_d = RxIdle;
                    end else begin
                        rx_state_d = RxWait;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RxWait: begin
                // Framing error: hold off until the line returns to idle.
                if (rx_sync_q) begin
                    rx_state_d = RxIdle;
                end
            end
            default: begin
                rx_state_d = RxIdle;
            end
        endcase
    end

    assign rx_data = rx_data_q;
    assign rx_recv = rx_recv_q;

endmodule

// File: tb/tb_uart_transceiver.sv
// Testbench for uart_transceiver: a loopback DUT plus an echo transmitter fed
// by the DUT receiver, with the echo's own receiver decoding the echoed stream.
module tb_uart_transceiver;

    localparam int unsigned DB  = 8;
    localparam int unsigned CPB = 4;

    localparam int KTx       = 0;  // {tx, tx_sent} sampled this cycle
    localparam int KRxData   = 1;
    localparam int KSent     = 2;
    localparam int KEchoSent = 3;
    localparam int KRxPend   = 4;
    localparam int KEchoPend = 5;
    localparam int KPeriod   = 6;
    localparam int KBound    = 7;

    typedef struct packed {
        int kind;
        int exp;
        int act;
    } probe_t;

    logic          clk;
    logic          rst;
    logic          erst;
    logic [DB-1:0] tx_data;
    logic          tx_send;
    logic          tx_sent;
    logic          tx;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_recv;
    logic          loop_en;
    logic          rx_drv;

    logic          e_tx_sent;
    logic          e_tx;
    logic [DB-1:0] e_rx_data;
    logic          e_rx_recv;

    assign rx = loop_en ? tx : rx_drv;

    uart_transceiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_send (tx_send),
        .tx_sent (tx_sent),
        .tx      (tx),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_recv (rx_recv)
    );

    uart_transceiver #(.DATA_BITS(DB), .CLKS_PER_BIT(CPB)) u_echo (
        .clk     (clk),
        .rst     (erst),
        .tx_data (rx_data),
        .tx_send (rx_recv),
        .tx_sent (e_tx_sent),
        .tx      (e_tx),
        .rx      (e_tx),
        .rx_data (e_rx_data),
        .rx_recv (e_rx_recv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int            n_pass  = 0;
    int            n_total = 0;
    int            sent_cnt = 0;
    int            e_sent_cnt = 0;
    logic [DB-1:0] exp_rx[$];
    logic [DB-1:0] exp_echo[$];
    probe_t        probes[$];

    function automatic string kname(int k);
        case (k)
            KTx:       return "tx_line";
            KRxData:   return "rx_data_hold";
            KSent:     return "tx_sent_count";
            KEchoSent: return "echo_sent_count";
            KRxPend:   return "rx_pending";
            KEchoPend: return "echo_pending";
            KPeriod:   return "frame_period";
            default:   return "wait_bound";
        endcase
    endfunction

    // Monitor / scoreboard: pops expectations when the DUT presents output.
    initial begin
        probe_t        p;
        int            act;
        logic [DB-1:0] e;
        forever begin
            @(negedge clk);
            if (tx_sent) sent_cnt++;
            if (e_tx_sent) e_sent_cnt++;
            if (rx_recv) begin
                n_total++;
                if (exp_rx.size() == 0) begin
                    $display("FAIL rx_byte: got %02h, required no strobe (cycle %0d)", rx_data, cyc);
                end else begin
                    e = exp_rx.pop_front();
                    if (rx_data == e) n_pass++;
                    else $display("FAIL rx_byte: got %02h, required %02h", rx_data, e);
                end
            end
            if (e_rx_recv) begin
                n_total++;
                if (exp_echo.size() == 0) begin
                    $display("FAIL echo_byte: got %02h, required no strobe", e_rx_data);
                end else begin
                    e = exp_echo.pop_front();
                    if (e_rx_data == e) n_pass++;
                    else $display("FAIL echo_byte: got %02h, required %02h", e_rx_data, e);
                end
            end
            if (probes.size() != 0) begin
                p = probes.pop_front();
                case (p.kind)
                    KTx:       act = {30'd0, tx, tx_sent};
                    KRxData:   act = {24'd0, rx_data};
                    KSent:     act = sent_cnt;
                    KEchoSent: act = e_sent_cnt;
                    KRxPend:   act = exp_rx.size();
                    KEchoPend: act = exp_echo.size();
                    default:   act = p.act;
                endcase
                n_total++;
                if (act == p.exp) n_pass++;
                else $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                              kname(p.kind), act, p.exp, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic probe(input int k, input int e, input int a);
        probe_t p;
        p.kind = k;
        p.exp  = e;
        p.act  = a;
        probes.push_back(p);
    endtask

    task automatic push_byte(input logic [DB-1:0] b);
        exp_rx.push_back(b);
        exp_echo.push_back(b);
    endtask

    // Returns at the negedge inside the tx_sent cycle.
    task automatic wait_sent(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_sent) return;
        end
        probe(KBound, 1, 0);
    endtask

    task automatic drive_frame(input logic [DB-1:0] b, input logic stop);
        rx_drv = 1'b0;
        tick(CPB);
        for (int i = 0; i < DB; i++) begin
            rx_drv = b[i];
            tick(CPB);
        end
        rx_drv = stop;
        tick(CPB);
        rx_drv = 1'b1;
        tick(CPB);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    int prev;

    initial begin
        rst     = 1'b1;
        erst    = 1'b1;
        tx_data = '0;
        tx_send = 1'b0;
        loop_en = 1'b1;
        rx_drv  = 1'b1;
        prev    = 0;

        // Reset values
        @(posedge clk);
        @(posedge clk);
        probe(KTx, 2, 0);
        probe(KRxData, 0, 0);
        @(negedge clk);
        rst  = 1'b0;
        erst = 1'b0;
        tick(4);

        // Single frame 0x01: 0 x4, 1 x4, 0 x28, 1 x4, tx_sent at cycle 40
        tx_data = 8'h01;
        tx_send = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 44; i++) begin
            int b;
            b = (i <= 4) ? 0 : (i <= 8) ? 1 : (i <= 36) ? 0 : 1;
            probe(KTx, b * 2 + ((i == 40) ? 1 : 0), 0);
        end
        push_byte(8'h01);
        @(negedge clk);
        tx_send = 1'b0;
        tick(80);

        // Loopback 0xA5; tx_data changes mid-frame without effect
        tx_data = 8'hA5;
        tx_send = 1'b1;
        @(posedge clk);
        push_byte(8'hA5);
        @(negedge clk);
        tx_send = 1'b0;
        tx_data = 8'h5A;
        wait_sent(60);
        repeat (4) @(posedge clk);
        probe(KRxPend, 0, 0);
        tick(80);

        // Streaming 0x00..0x05, tx_send held high
        tx_data = 8'h00;
        tx_send = 1'b1;
        @(posedge clk);
        push_byte(8'h00);
        for (int k = 1; k <= 6; k++) begin
            wait_sent(60);
            if (k > 1) probe(KPeriod, 40, cyc - prev);
            prev = cyc;
            if (k < 6) begin
                tx_data = DB'(k);
                push_byte(DB'(k));
            end else begin
                tx_send = 1'b0;
            end
        end
        tick(120);

        // Glitch, then valid 0x3C
        loop_en = 1'b0;
        tick(2);
        rx_drv = 1'b0;
        tick(1);
        rx_drv = 1'b1;
        tick(20);
        push_byte(8'h3C);
        drive_frame(8'h3C, 1'b1);
        tick(60);

        // Framing error on 0x55, rx_data must hold 0x3C, then valid 0x96
        drive_frame(8'h55, 1'b0);
        tick(20);
        @(posedge clk);
        probe(KRxData, 32'h3C, 0);
        tick(4);
        push_byte(8'h96);
        drive_frame(8'h96, 1'b1);
        tick(80);

        // Reset while TX and RX are both in DATA
        loop_en = 1'b1;
        tick(2);
        tx_data = 8'h00;
        tx_send = 1'b1;
        tick(1);
        tx_send = 1'b0;
        tick(14);
        rst = 1'b1;
        @(posedge clk);
        probe(KTx, 2, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(60);

        // Send 0xFF after the reset
        tx_data = 8'hFF;
        tx_send = 1'b1;
        @(posedge clk);
        push_byte(8'hFF);
        @(negedge clk);
        tx_send = 1'b0;
        wait_sent(60);
        tick(120);

        @(posedge clk);
        probe(KSent, 9, 0);
        probe(KEchoSent, 11, 0);
        probe(KRxPend, 0, 0);
        probe(KEchoPend, 0, 0);
        tick(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Single-clock UART block with an independent transmitter and receiver sharing one clock and one reset.
- Fixed-rate 8N1-style framing; each bit lasts a parameterised number of clock cycles; no baud generator or FIFO.
- Sits between system logic and the serial pins, or is wired TX-to-RX for loopback.
- The receiver's byte/strobe outputs drive a transmitter's data/send inputs directly for echo.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal minimum 4.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_BITS  byte to transmit; captured when a frame starts.
- tx_send  input  1  transmit request, level-sensitive; held high, frames go back-to-back.
- tx_sent  output  1  one-cycle pulse in the last cycle of each stop bit.
- tx  output  1  serial out; idle high; registered.
- rx  input  1  serial in, asynchronous.
- rx_data  output  DATA_BITS  last received byte; holds until the next valid frame.
- rx_recv  output  1  one-cycle strobe; rx_data is valid in the same cycle.

Behaviour:
- Reset values: tx=1, tx_sent=0, rx_recv=0, rx_data=0. Both FSMs go to IDLE. The synchroniser flops go to 1.
- Reset mid-frame aborts the frame; tx is 1 in the cycle after rst is sampled.
- Frame format: start bit (0), DATA_BITS data bits LSB first, stop bit (1). Every bit is CLKS_PER_BIT cycles.
- Frame length is (DATA_BITS+2)*CLKS_PER_BIT cycles, i.e. 40 with the defaults.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter counts 0..CLKS_PER_BIT-1 and an index counts 0..DATA_BITS-1.
- IDLE to START: when tx_send=1 at a clock edge, tx_data goes into a shift register and tx drives 0 from the next cycle.
- tx_data may change freely mid-frame without affecting the frame in progress.
- STOP: tx=1 for CLKS_PER_BIT cycles. tx_sent=1 during the final STOP cycle only.
- After the final STOP cycle, if tx_send=1 the FSM goes straight to START, capturing tx_data at that edge. There is no idle gap.
- The byte captured for the next frame is the value present at the edge that ends tx_sent. Logic that updates tx_data on the tx_sent pulse therefore gets the new byte sent.
- If tx_send=0 at the end of STOP, the FSM goes to IDLE with tx=1.
- RX input path: rx passes through a 2-flop synchroniser; all RX logic uses the synchronised signal.
- RX FSM states: IDLE, START, DATA, STOP.
- IDLE: wait for the synchronised line to be 0, then enter START and reset the bit counter.
- START: at count CLKS_PER_BIT/2-1 (mid-bit), the line must still be 0, otherwise return to IDLE (glitch rejection). On success, restart the counter and enter DATA.
- DATA: sample every CLKS_PER_BIT cycles at mid-bit and shift LSB first. After DATA_BITS samples, enter STOP.
- STOP: sample at mid-bit.
  - If 1: load rx_data, pulse rx_recv for one cycle, go to IDLE immediately without waiting for the end of the stop bit. This gives a half-bit margin for back-to-back frames.
  - If 0 (framing error): no strobe, rx_data unchanged, go to a wait state until the line is 1, then IDLE.
- Total RX latency from the line's start-bit falling edge to rx_recv is about 2 + (DATA_BITS+1)*CLKS_PER_BIT + CLKS_PER_BIT/2 cycles.
- TX and RX are fully independent; simultaneous activity has no interaction.

Test Plan:
- Single frame: rst for 2 cycles, tx_data=0x01, tx_send pulsed for 1 cycle.
  - tx is 0 for 4 cycles, then 1 for 4, then 0 for 28, then 1 for 4.
  - tx_sent pulses once at cycle 40 of the frame, then tx stays 1.
- Loopback: tx wired to rx, tx_data=0xA5 with one send -> exactly one rx_recv pulse with rx_data=0xA5, arriving before tx_sent + 4 cycles.
- Streaming: tx_send held at 1, tx_data incremented on each tx_sent pulse starting at 0x00.
  - Frames are exactly 40 cycles apart with no idle gap.
  - rx_recv delivers 0x00, 0x01, 0x02, ... in order with none missed.
  - An echo transmitter driven by rx_data/rx_recv reproduces the same serial stream delayed.
- Glitch: rx driven low for 1 cycle then high -> no rx_recv, and RX is back in IDLE; a following valid frame carrying 0x3C is received correctly.
- Framing error: a frame carrying 0x55 with a stop bit of 0 -> no rx_recv and rx_data keeps its previous value; the next valid frame is received.
- Reset mid-frame: rst asserted during TX DATA and during RX DATA.
  - The next cycle shows tx=1 and no tx_sent/rx_recv pulse.
  - A subsequent send of 0xFF loops back correctly.
